store_order_ctrl: RTL and testbench
===================================

Name: store_order_ctrl

Overview:
- Store-issue controller between the LSU store unit and the write-through dcache/AXI write path.
- Tracks outstanding stores and caps them at MaxOutstandingStores.
- Serialises stores to non-idempotent regions: drains all prior stores, issues the store, then waits for its response.
- Drains all outstanding stores on a fence and signals completion.

Parameters:
- MaxOutstandingStores, 7: maximum stores issued but not yet acknowledged.
- CntWidth, $clog2(MaxOutstandingStores+1) (3): width of the outstanding counter.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous reset, active-high.
- st_req_i  input  1  LSU requests to issue one store this cycle; held until granted or withdrawn.
- st_nonidem_i  input  1  requested store targets a non-idempotent region; valid with st_req_i.
- st_gnt_o  output  1  store issued this cycle (issue = st_req_i & st_gnt_o); combinational.
- st_ack_i  input  1  one write response received (one store retired).
- fence_i  input  1  fence request, single-cycle pulse.
- fence_done_o  output  1  single-cycle pulse: all stores before the fence are acknowledged.
- busy_o  output  1  state != NORMAL or outstanding_o != 0.
- outstanding_o  output  CntWidth  current outstanding count (registered).
- err_o  output  1  sticky: ack received with count 0.

Behaviour:
- Reset (asynchronous, rst_i=1):
  - state=NORMAL, cnt=0, fence_pend=0, err_o=0.
  - st_gnt_o=0, fence_done_o=0, busy_o=0.
- Counter update: cnt_next = cnt + issue - (st_ack_i & cnt!=0). An issue and an ack in the same cycle leave cnt unchanged.
- Ack with cnt==0: ignored; err_o set, cleared only by reset.
- NORMAL state:
  - fence_i or fence_pend (priority over stores): st_gnt_o=0; go to FENCE_DRAIN next cycle; clear fence_pend.
  - Idempotent store (st_req_i & !st_nonidem_i): st_gnt_o=1 iff cnt<Max or st_ack_i. At cnt==Max with an ack in the same cycle, the store is granted and cnt stays Max.
  - Non-idempotent store with cnt==0: st_gnt_o=1; go to NI_WAIT.
  - Non-idempotent store with cnt!=0: st_gnt_o=0; go to NI_DRAIN.
- FENCE_DRAIN state:
  - st_gnt_o=0.
  - fence_done_o = (cnt==0), using the registered count.
  - When cnt==0, return to NORMAL next cycle.
  - Latency: if cnt==0 when fence_i is sampled in cycle N, the done pulse is in cycle N+1 and state is NORMAL in cycle N+2.
- NI_DRAIN state:
  - st_gnt_o = st_req_i & (cnt==0).
  - On grant, go to NI_WAIT.
  - If st_req_i drops (LSU flush), go to NORMAL.
- NI_WAIT state:
  - st_gnt_o=0; cnt is 1.
  - On st_ack_i, go to NORMAL next cycle; the next store can be granted one cycle after the ack.
- fence_i outside NORMAL: sets fence_pend, which is serviced on the next NORMAL cycle ahead of any store. Repeated fence_i while fence_pend is set merge into one.
- A fence does not wait for stores requested after fence_i; those are held until fence_done_o.
- Reset mid-operation: all state discarded; no fence_done_o pulse is generated for the aborted fence.
- Assertions:
  - cnt never exceeds Max.
  - st_gnt_o is never 1 without st_req_i.
  - fence_done_o is never high for two consecutive cycles.

Test Plan:
- Throughput cap:
  - 8 idempotent requests back-to-back with no acks -> 7 grants in cycles 0-6, outstanding_o=7, grant denied in cycle 7.
  - Then assert st_ack_i in cycle 9 -> grant in cycle 9, outstanding_o stays 7.
- Fence with 3 outstanding:
  - fence_i in cycle 0, acks in cycles 2, 4, 6, st_req_i held high -> no grants in cycles 0-7.
  - fence_done_o high in cycle 7 only; grant in cycle 8.
- Immediate fence: fence_i with cnt=0 in cycle 0 -> fence_done_o in cycle 1, state NORMAL in cycle 2.
- Non-idempotent ordering:
  - 2 outstanding, non-idempotent request in cycle 0, acks in cycles 3 and 5 -> grant in cycle 6.
  - Ack in cycle 10 -> next idempotent store granted in cycle 11; outstanding_o=1 throughout cycles 7-10.
- Error and flush:
  - st_ack_i with cnt=0 -> err_o=1 and stays 1, outstanding_o stays 0.
  - Non-idempotent request withdrawn in NI_DRAIN -> state returns to NORMAL, no grant.
- Reset mid-drain: rst_i asserted in FENCE_DRAIN with cnt=4 -> all outputs 0 immediately; no fence_done_o after reset release.

Source files
------------

// File: rtl/store_order_ctrl.sv
// Store-issue controller: caps outstanding stores, serialises non-idempotent
// stores and drains all outstanding stores on a fence.
module store_order_ctrl #(
  parameter int MaxOutstandingStores = 7,
  parameter int CntWidth             = $clog2(MaxOutstandingStores + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                st_req_i,
  input  logic                st_nonidem_i,
  output logic                st_gnt_o,
  input  logic                st_ack_i,
  input  logic                fence_i,
  output logic                fence_done_o,
  output logic                busy_o,
  output logic [CntWidth-1:0] outstanding_o,
  output logic                err_o
);

  typedef enum logic [1:0] {
    NORMAL      = 2'd0,
    FENCE_DRAIN = 2'd1,
    NI_DRAIN    = 2'd2,
    NI_WAIT     = 2'd3
  } state_e;

  localparam logic [CntWidth-1:0] ZERO_CNT = {CntWidth{1'b0}};
  localparam logic [CntWidth-1:0] ONE_CNT  = CntWidth'(1);
  localparam logic [CntWidth-1:0] MAX_CNT  = CntWidth'(MaxOutstandingStores);

  state_e                state_r;
  state_e                state_s;
  logic [CntWidth-1:0]   cnt_r;
  logic                  fence_pend_r;
  logic                  err_r;
  logic                  gnt_s;
  logic                  done_s;
  logic                  issue_s;
  logic                  ack_valid_s;
  logic                  cnt_zero_s;

  assign cnt_zero_s  = (cnt_r == ZERO_CNT);
  assign issue_s     = st_req_i & gnt_s;
  // An ack with nothing outstanding is an error and must not underflow the count.
  assign ack_valid_s = st_ack_i & ~cnt_zero_s;

  // Next-state, grant and fence-done decode.
  always_comb begin
    state_s = state_r;
    gnt_s   = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      NORMAL: begin
        if (fence_i | fence_pend_r) begin
          state_s = FENCE_DRAIN;
        end else if (st_req_i & ~st_nonidem_i) begin
          // A same-cycle ack frees a slot, so a full queue can still accept.
          gnt_s = (cnt_r < MAX_CNT) | st_ack_i;
        end else if (st_req_i & st_nonidem_i) begin
          if (cnt_zero_s) begin
            gnt_s   = 1'b1;
            state_s = NI_WAIT;
          end else begin
            state_s = NI_DRAIN;
          end
        end else begin
          state_s = NORMAL;
        end
      end
      FENCE_DRAIN: begin
        done_s = cnt_zero_s;
        if (cnt_zero_s) begin
          state_s = NORMAL;
        end else begin
          state_s = FENCE_DRAIN;
        end
      end
      NI_DRAIN: begin
        gnt_s = st_req_i & cnt_zero_s;
        if (gnt_s) begin
          state_s = NI_WAIT;
        end else if (!st_req_i) begin
          state_s = NORMAL;
        end else begin
          state_s = NI_DRAIN;
        end
      end
      NI_WAIT: begin
        if (st_ack_i) begin
          state_s = NORMAL;
        end else begin
          state_s = NI_WAIT;
        end
      end
      default: begin
        state_s = NORMAL;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= NORMAL;
    end else begin
      state_r <= state_s;
    end
  end

  // Outstanding-store counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r <= ZERO_CNT;
    end else begin
      case ({issue_s, ack_valid_s})
        2'b10:   cnt_r <= cnt_r + ONE_CNT;
        2'b01:   cnt_r <= cnt_r - ONE_CNT;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Fences arriving outside NORMAL are remembered (and merged) until serviced.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fence_pend_r <= 1'b0;
    end else if (state_r == NORMAL) begin
      fence_pend_r <= 1'b0;
    end else if (fence_i) begin
      fence_pend_r <= 1'b1;
    end else begin
      fence_pend_r <= fence_pend_r;
    end
  end

  // Sticky error on a spurious ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | (st_ack_i & cnt_zero_s);
    end
  end

  // Grant and done are forced low while reset is held.
  assign st_gnt_o      = gnt_s & ~rst_i;
  assign fence_done_o  = done_s & ~rst_i;
  assign busy_o        = (state_r != NORMAL) | ~cnt_zero_s;
  assign outstanding_o = cnt_r;
  assign err_o         = err_r;

  store_order_ctrl_chk #(
    .MaxOutstandingStores (MaxOutstandingStores),
    .CntWidth             (CntWidth)
  ) u_chk (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cnt_i        (cnt_r),
    .st_req_i     (st_req_i),
    .st_gnt_i     (st_gnt_o),
    .fence_done_i (fence_done_o)
  );

endmodule

// Runtime invariants of the store-order controller.
module store_order_ctrl_chk #(
  parameter int MaxOutstandingStores = 7,
  parameter int CntWidth             = 3
) (
  input logic                clk_i,
  input logic                rst_i,
  input logic [CntWidth-1:0] cnt_i,
  input logic                st_req_i,
  input logic                st_gnt_i,
  input logic                fence_done_i
);

  localparam logic [CntWidth-1:0] MAX_CNT = CntWidth'(MaxOutstandingStores);

  a_cnt_max: assert property (@(posedge clk_i) disable iff (rst_i) cnt_i <= MAX_CNT);
  a_gnt_req: assert property (@(posedge clk_i) disable iff (rst_i) !(st_gnt_i && !st_req_i));
  a_done_pulse: assert property (@(posedge clk_i) disable iff (rst_i)
                                 fence_done_i |=> !fence_done_i);

endmodule

// File: tb/tb_store_order_ctrl.sv
// Scoreboard bench for store_order_ctrl: directed scenarios plus random traffic
// checked against an ordering-rule model of outstanding stores.
module tb_store_order_ctrl;

  localparam int MAX = 7;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       st_req_i, st_nonidem_i, st_ack_i, fence_i;
  logic       st_gnt_o, fence_done_o, busy_o, err_o;
  logic [2:0] outstanding_o;

  store_order_ctrl #(.MaxOutstandingStores(MAX)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .st_req_i(st_req_i), .st_nonidem_i(st_nonidem_i),
    .st_gnt_o(st_gnt_o), .st_ack_i(st_ack_i), .fence_i(fence_i),
    .fence_done_o(fence_done_o), .busy_o(busy_o), .outstanding_o(outstanding_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       gnt;
    logic       done;
    logic       busy;
    logic       err;
    logic [2:0] outst;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: outstanding stores as a number, ordering obligations as flags.
  int m_cnt;
  bit m_err, m_fencing, m_fence_queued, m_ni_hold, m_ni_inflight;

  task automatic model_reset();
    m_cnt = 0; m_err = 0; m_fencing = 0; m_fence_queued = 0;
    m_ni_hold = 0; m_ni_inflight = 0;
  endtask

  task automatic model_cycle(input bit req, input bit ni, input bit ack, input bit fence,
                             output exp_t e);
    bit quiet;
    bit g;
    int old_cnt;
    quiet   = !(m_fencing || m_ni_hold || m_ni_inflight);
    old_cnt = m_cnt;
    if (m_fencing || m_ni_inflight) g = 0;
    else if (m_ni_hold)             g = req && (m_cnt == 0);
    else if (fence || m_fence_queued) g = 0;
    else if (!req)                  g = 0;
    else if (!ni)                   g = (m_cnt < MAX) || ack;
    else                            g = (m_cnt == 0);
    e.gnt   = g;
    e.done  = m_fencing && (m_cnt == 0);
    e.busy  = !quiet || (m_cnt != 0);
    e.err   = m_err;
    e.outst = m_cnt[2:0];
    if (ack && old_cnt == 0) m_err = 1;
    m_cnt = m_cnt + (g ? 1 : 0) - ((ack && old_cnt > 0) ? 1 : 0);
    if (quiet) begin
      if (fence || m_fence_queued) begin
        m_fencing = 1; m_fence_queued = 0;
      end else if (req && ni) begin
        if (g) m_ni_inflight = 1;
        else   m_ni_hold = 1;
      end
    end else begin
      if (fence) m_fence_queued = 1;
      if (m_fencing && old_cnt == 0) m_fencing = 0;
      if (m_ni_hold) begin
        if (g) begin m_ni_hold = 0; m_ni_inflight = 1; end
        else if (!req) m_ni_hold = 0;
      end else if (m_ni_inflight && ack) begin
        m_ni_inflight = 0;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // One clock cycle of stimulus: drive at negedge, queue the predicted response.
  task automatic cyc(input bit req, input bit ni, input bit ack, input bit fence);
    exp_t e;
    @(negedge clk_i);
    st_req_i = req; st_nonidem_i = ni; st_ack_i = ack; fence_i = fence;
    model_cycle(req, ni, ack, fence, e);
    exp_q.push_back(e);
  endtask

  // Monitor: compare the oldest prediction with the DUT, away from the edge.
  always @(negedge clk_i) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("gnt",  int'(st_gnt_o),      int'(e.gnt));
      chk("done", int'(fence_done_o),  int'(e.done));
      chk("busy", int'(busy_o),        int'(e.busy));
      chk("err",  int'(err_o),         int'(e.err));
      chk("outstanding", int'(outstanding_o), int'(e.outst));
    end
  end

  task automatic release_reset();
    @(negedge clk_i);
    st_req_i = 0; st_nonidem_i = 0; st_ack_i = 0; fence_i = 0;
    rst_i = 0;
    model_reset();
  endtask

  initial begin
    rst_i = 1; st_req_i = 1; st_nonidem_i = 0; st_ack_i = 0; fence_i = 0;
    model_reset();
    #3;
    chk("rst_gnt", int'(st_gnt_o), 0);
    chk("rst_done", int'(fence_done_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_outstanding", int'(outstanding_o), 0);
    chk("rst_err", int'(err_o), 0);
    release_reset();

    // Throughput cap: 7 grants then denial; same-cycle ack allows a grant at the cap.
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0);
    #1 chk("cap_deny_gnt", int'(st_gnt_o), 0);
    chk("cap_outstanding", int'(outstanding_o), 7);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    #1 chk("cap_ack_gnt", int'(st_gnt_o), 1);
    cyc(0, 0, 0, 0);
    #1 chk("cap_hold", int'(outstanding_o), 7);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    #1 chk("drained", int'(outstanding_o), 0);

    // Fence with 3 outstanding, acks in cycles 2, 4, 6, request held.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
    for (int c = 0; c < 8; c++) begin
      cyc(1, 0, (c == 2 || c == 4 || c == 6), (c == 0));
      #1 chk("fence_nogrant", int'(st_gnt_o), 0);
      chk("fence_done_cycle", int'(fence_done_o), (c == 7) ? 1 : 0);
    end
    cyc(1, 0, 0, 0);
    #1 chk("post_fence_gnt", int'(st_gnt_o), 1);
    cyc(0, 0, 1, 0);

    // Immediate fence.
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    #1 chk("imm_done", int'(fence_done_o), 1);
    cyc(0, 0, 0, 0);
    #1 chk("imm_normal", int'(busy_o), 0);

    // Non-idempotent ordering with 2 outstanding.
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    for (int c = 0; c < 11; c++) begin
      cyc((c <= 6) ? 1'b1 : (c == 10), (c <= 6), (c == 3 || c == 5 || c == 10), 0);
      if (c >= 7 && c <= 10) begin #1 chk("ni_outstanding", int'(outstanding_o), 1); end
      if (c == 6) begin #1 chk("ni_gnt6", int'(st_gnt_o), 1); end
    end
    cyc(1, 0, 0, 0);
    #1 chk("ni_next_gnt", int'(st_gnt_o), 1);
    cyc(0, 0, 1, 0);

    // Spurious ack sets the sticky error.
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    #1 chk("err_sticky", int'(err_o), 1);
    chk("err_outstanding", int'(outstanding_o), 0);

    // Non-idempotent request withdrawn while draining.
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    #1 chk("flush_normal_gnt", int'(st_gnt_o), 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);

    // Reset while draining a fence with 4 outstanding.
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    #4 rst_i = 1;
    #1;
    chk("mid_rst_gnt", int'(st_gnt_o), 0);
    chk("mid_rst_done", int'(fence_done_o), 0);
    chk("mid_rst_busy", int'(busy_o), 0);
    chk("mid_rst_outstanding", int'(outstanding_o), 0);
    chk("mid_rst_err", int'(err_o), 0);
    @(negedge clk_i);
    release_reset();
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
          $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0);
    end
    cyc(0, 0, 0, 0);
    #20;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
